if_id_register: RTL

- Pipeline register between the IF stage (p_counter, instructionMemory, sumador, PC mux) and the ID stage.
- Captures the fetched instruction and PC+1 each enabled cycle.
- Handles stall (hold), flush (bubble insertion) and halt-instruction detection.
- Runs a small halt state machine that freezes the PC and reports when the pipeline front end has drained. Also keeps a saturating count of accepted instructions for the debug unit.

---
 rtl/if_id_register_pkg.sv | 18 +
 rtl/if_id_register_if.sv | 23 ++
 rtl/if_id_register_sat_counter.sv | 23 ++
 rtl/if_id_register.sv | 104 ++++++++++
 4 files changed

// File: rtl/if_id_register_pkg.sv
// Shared definitions for the IF/ID pipeline register: halt FSM state encoding
// and the special instruction encodings.
package if_id_register_pkg;

  localparam logic [1:0] ST_RUN_ENC       = 2'd0;
  localparam logic [1:0] ST_HALT_SEEN_ENC = 2'd1;
  localparam logic [1:0] ST_HALTED_ENC    = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN       = ST_RUN_ENC,
    ST_HALT_SEEN = ST_HALT_SEEN_ENC,
    ST_HALTED    = ST_HALTED_ENC
  } halt_state_t;

  localparam logic [31:0] HALT_INSTR = 32'hFC000000;
  localparam logic [31:0] NOP_INSTR  = 32'h00000000;

endpackage

// File: rtl/if_id_register_if.sv
// Fetch-to-decode bus: fetched instruction/PC+1 in, registered copies out to ID.
interface if_id_register_if #(
  parameter int NB_DATA = 32
);

  logic [NB_DATA-1:0] instr;
  logic [NB_DATA-1:0] pc_4;
  logic               halt_signal;
  logic [NB_DATA-1:0] id_instr;
  logic [NB_DATA-1:0] id_pc_4;
  logic               id_valid;

  modport master (
    output instr, pc_4, halt_signal,
    input  id_instr, id_pc_4, id_valid
  );

  modport slave (
    input  instr, pc_4, halt_signal,
    output id_instr, id_pc_4, id_valid
  );

endinterface

// File: rtl/if_id_register_sat_counter.sv
// Saturating up-counter with synchronous clear; shared with the debug unit.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall/flush handling, halt detection FSM and
// a saturating accepted-instruction counter.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RUN       | normal fetch; loads capture the fetched instruction
// HALT_SEEN | halt instruction held in the register, PC frozen
// HALTED    | front end drained; register holds a bubble until reset
module if_id_register
  import if_id_register_pkg::*;
#(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_COUNT  = 16,
  parameter logic [NB_DATA-1:0] NOP_INSTR = if_id_register_pkg::NOP_INSTR
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_flush,
  if_id_register_if.slave     io_bus,
  output logic                o_pc_hold,
  output logic                o_halted,
  output logic [NB_COUNT-1:0] o_fetch_count
);

  halt_state_t        r_state;
  logic [NB_DATA-1:0] r_instr;
  logic [NB_DATA-1:0] r_pc_4;
  logic               r_valid;
  logic               r_pc_hold;
  logic               r_halted;

  logic w_load;
  logic w_count_en;

  assign w_load     = i_enable & ~i_stall;
  // Only genuine captures in RUN are counted; bubbles and halt-path writes are not.
  assign w_count_en = w_load & ~i_flush & (r_state == ST_RUN);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_RUN;
      r_instr   <= NOP_INSTR;
      r_pc_4    <= '0;
      r_valid   <= 1'b0;
      r_pc_hold <= 1'b0;
      r_halted  <= 1'b0;
    end else if (i_enable) begin
      case (r_state)
        ST_RUN: begin
          if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end else if (!i_stall) begin
            r_instr <= io_bus.instr;
            r_pc_4  <= io_bus.pc_4;
            r_valid <= 1'b1;
            if (io_bus.halt_signal) begin
              r_state   <= ST_HALT_SEEN;
              r_pc_hold <= 1'b1;
            end
          end
        end
        ST_HALT_SEEN: begin
          if (i_flush) begin
            r_instr   <= NOP_INSTR;
            r_valid   <= 1'b0;
            r_pc_hold <= 1'b0;
            r_state   <= ST_RUN;
          end else if (!i_stall) begin
            // Instruction at the frozen PC is discarded; the halt has drained.
            r_instr  <= NOP_INSTR;
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (NB_COUNT)
  ) u_fetch_counter (
    .i_clk    (i_clk),
    .i_clear  (i_reset),
    .i_enable (w_count_en),
    .o_count  (o_fetch_count)
  );

  assign io_bus.id_instr = r_instr;
  assign io_bus.id_pc_4  = r_pc_4;
  assign io_bus.id_valid = r_valid;
  assign o_pc_hold       = r_pc_hold;
  assign o_halted        = r_halted;

endmodule
